pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Consumes the PLL's global clock and its raw `locked` flag.
- Produces a clean, synchronously deasserted system reset (`sys_reset_n`) for all logic in the PLL clock domain, such as the quadrature decoders.
- Reset is released only after lock has been stable for a filter window plus a hold window.
- Loss of lock re-asserts reset immediately; lock-loss events are counted for diagnostics.

Parameters:
- SYNC_STAGES, 2: flip-flop stages synchronising `locked` into `clk` (minimum 2).
- LOCK_FILTER, 16: consecutive synchronised-high cycles of `locked` required before HOLD (minimum 1).
- HOLD_CYCLES, 1024: cycles reset stays asserted after the filter passes (minimum 1).
- CNT_W, 16: width of the shared phase counter; must hold max(LOCK_FILTER, HOLD_CYCLES)-1.
- LOSS_CNT_W, 8: width of the lock-loss counter.

Ports:
- clk, in, 1: PLL global clock output.
- rst_n, in, 1: asynchronous active-low reset (board power-on reset).
- locked, in, 1: raw PLL lock flag, asynchronous to `clk`.
- sw_reset_req, in, 1: single-cycle synchronous request to re-run the HOLD phase.
- clear_status, in, 1: synchronous clear of `lock_loss_count` and `lock_lost`.
- sys_reset_n, out, 1: registered active-low system reset.
- sys_ready, out, 1: registered; high only in RUN.
- state, out, 2: current state encoding (WAIT_LOCK=0, FILTER=1, HOLD=2, RUN=3).
- lock_loss_count, out, LOSS_CNT_W: saturating count of RUN-to-lock-loss events.
- lock_lost, out, 1: sticky flag, set on any lock loss in RUN.

Behaviour:
- Reset: `rst_n`=0 asynchronously forces the following, held while `rst_n`=0:
  - state=WAIT_LOCK;
  - sys_reset_n=0, sys_ready=0;
  - synchroniser flops=0, phase counter=0;
  - lock_loss_count=0, lock_lost=0.
- Reset mid-operation behaves identically; there is no partial state.
- `locked_sync` is the output of the SYNC_STAGES chain. All FSM decisions use `locked_sync` only.
- sys_reset_n and sys_ready are flops updated on the same edge as `state`:
  - sys_reset_n=1 exactly when the next state is RUN;
  - sys_ready equals sys_reset_n.
- WAIT_LOCK:
  - counter held at 0;
  - `locked_sync`=1 -> FILTER with counter=0.
- FILTER:
  - `locked_sync`=0 -> WAIT_LOCK;
  - otherwise, if counter==LOCK_FILTER-1 -> HOLD with counter=0;
  - else counter+1.
  - FILTER therefore lasts exactly LOCK_FILTER cycles.
- HOLD:
  - `locked_sync`=0 -> WAIT_LOCK;
  - otherwise, if counter==HOLD_CYCLES-1 -> RUN;
  - else counter+1.
  - HOLD lasts exactly HOLD_CYCLES cycles.
- RUN:
  - `locked_sync`=0 -> WAIT_LOCK on that edge; sys_reset_n=0 from that edge; increment lock_loss_count (saturating at all-ones); set lock_lost.
  - Else `sw_reset_req`=1 -> HOLD with counter=0; sys_reset_n=0; no status change.
- `sw_reset_req` is ignored outside RUN.
- Simultaneous lock loss and `sw_reset_req` in RUN: the loss wins (WAIT_LOCK, counted).
- `clear_status`:
  - zeroes lock_loss_count and lock_lost on the next edge;
  - if a loss event occurs on the same edge, the result is count=1, lock_lost=1.
- Latency: from the first clk edge sampling `locked`=1 (held stable), sys_reset_n rises after exactly SYNC_STAGES+1+LOCK_FILTER+HOLD_CYCLES edges (1043 with defaults).
- Lock drop: sys_reset_n falls SYNC_STAGES+1 edges after the first edge sampling `locked`=0.
- A `locked` glitch shorter than one clock may be missed by the synchroniser; this is acceptable.
- Counter compare uses the full CNT_W width. No wrap-around is possible given the parameter constraint.

Test Plan:
- Power-up (SYNC_STAGES=2, LOCK_FILTER=4, HOLD_CYCLES=8): rst_n low 5 cycles, then high with locked=1 -> state walks 0->1->2->3; sys_reset_n and sys_ready rise exactly 15 edges after rst_n release; both are 0 before that.
- Filter abort: locked high 3 cycles (synchronised), then low 1 cycle, then high -> FILTER restarts from WAIT_LOCK; sys_reset_n rises 15 edges after the final rising sample.
- Lock loss in RUN: drop locked for 3 cycles -> sys_reset_n=0 three edges later, state=0, lock_loss_count=1, lock_lost=1.
- Repeat loss 300 times with LOSS_CNT_W=8 -> lock_loss_count=255 (saturated).
- sw_reset_req pulse in RUN -> sys_reset_n=0 for exactly 8 cycles, then 1; lock_loss_count unchanged.
- Same-edge events:
  - sw_reset_req together with lock loss -> state=0, count incremented;
  - clear_status together with lock loss -> count=1, lock_lost=1.
- Async reset asserted during HOLD -> all outputs 0 immediately, without waiting for a clock edge; normal sequence resumes after release.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Turns a raw, asynchronous PLL lock flag into a filtered system reset with a
// synchronous release, and counts lock losses for diagnostics.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 16,
  parameter int HOLD_CYCLES = 1024,
  parameter int CNT_W       = 16,
  parameter int LOSS_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  locked,
  input  logic                  sw_reset_req,
  input  logic                  clear_status,
  output logic                  sys_reset_n,
  output logic                  sys_ready,
  output logic [1:0]            state,
  output logic [LOSS_CNT_W-1:0] lock_loss_count,
  output logic                  lock_lost
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   locked_sync;
  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [LOSS_CNT_W-1:0]  loss_reg, loss_next;
  logic                   lost_reg, lost_next;
  logic                   rstn_reg, ready_reg;

  assign locked_sync = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= '0;
      state_reg <= WAIT_LOCK;
      cnt_reg   <= '0;
      loss_reg  <= '0;
      lost_reg  <= 1'b0;
      rstn_reg  <= 1'b0;
      ready_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], locked};
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      loss_reg  <= loss_next;
      lost_reg  <= lost_next;
      // Outputs track the next state so release coincides with entering RUN.
      rstn_reg  <= (state_next == RUN);
      ready_reg <= (state_next == RUN);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    loss_next  = loss_reg;
    lost_next  = lost_reg;
    if (clear_status) begin
      loss_next = '0;
      lost_next = 1'b0;
    end
    case (state_reg)
      WAIT_LOCK: begin
        cnt_next = '0;
        if (locked_sync) state_next = FILTER;
      end
      FILTER: begin
        if (!locked_sync) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == FILTER_LAST) begin
          state_next = HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!locked_sync) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == HOLD_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_sync) begin
          // Loss outranks both a software request and a same-edge clear.
          state_next = WAIT_LOCK;
          cnt_next   = '0;
          lost_next  = 1'b1;
          if (clear_status)
            loss_next = LOSS_CNT_W'(1);
          else if (loss_reg != '1)
            loss_next = loss_reg + LOSS_CNT_W'(1);
        end else if (sw_reset_req) begin
          state_next = HOLD;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = WAIT_LOCK;
        cnt_next   = '0;
      end
    endcase
  end

  assign sys_reset_n     = rstn_reg;
  assign sys_ready       = ready_reg;
  assign state           = state_reg;
  assign lock_loss_count = loss_reg;
  assign lock_lost       = lost_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all shadowed by a progress-count reference model.
module tb_pll_reset_sequencer;
  localparam int SS = 2;
  localparam int LF = 4;
  localparam int HC = 8;
  localparam int LW = 8;
  localparam int E_RUN = LF + HC + 1;
  localparam int LOSS_MAX = (1 << LW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          locked = 1'b1;
  logic          sw_reset_req = 1'b0;
  logic          clear_status = 1'b0;
  logic          sys_reset_n;
  logic          sys_ready;
  logic [1:0]    state;
  logic [LW-1:0] lock_loss_count;
  logic          lock_lost;

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;

  pll_reset_sequencer #(
    .SYNC_STAGES(SS), .LOCK_FILTER(LF), .HOLD_CYCLES(HC), .CNT_W(16), .LOSS_CNT_W(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .locked(locked), .sw_reset_req(sw_reset_req),
    .clear_status(clear_status), .sys_reset_n(sys_reset_n), .sys_ready(sys_ready),
    .state(state), .lock_loss_count(lock_loss_count), .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  // Model: e counts consecutive qualified lock cycles (0 = waiting, E_RUN = running).
  int e = 0;
  int m_cnt = 0;
  bit m_lost = 1'b0;
  bit q[$];

  function automatic int m_state();
    if (e == 0) return 0;
    if (e <= LF) return 1;
    if (e < E_RUN) return 2;
    return 3;
  endfunction

  initial begin
    bit ls, was_run;
    for (int i = 0; i < SS; i++) q.push_back(1'b0);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        e = 0; m_cnt = 0; m_lost = 1'b0;
        q.delete();
        for (int i = 0; i < SS; i++) q.push_back(1'b0);
      end else begin
        ls = q.pop_front();
        q.push_back(locked);
        was_run = (e == E_RUN);
        if (clear_status) begin m_cnt = 0; m_lost = 1'b0; end
        if (!ls) begin
          if (was_run) begin
            m_lost = 1'b1;
            if (m_cnt < LOSS_MAX) m_cnt++;
          end
          e = 0;
        end else if (was_run && sw_reset_req) begin
          e = LF + 1;
        end else if (e < E_RUN) begin
          e++;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("model_sys_reset_n", int'(sys_reset_n), int'(e == E_RUN));
        check("model_sys_ready", int'(sys_ready), int'(e == E_RUN));
        check("model_state", int'(state), m_state());
        check("model_loss_count", int'(lock_loss_count), m_cnt);
        check("model_lock_lost", int'(lock_lost), int'(m_lost));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rise(input string name, input int exp);
    int n;
    n = 0;
    for (int i = 1; i <= 2000; i++) begin
      step();
      n = i;
      if (sys_reset_n) break;
    end
    check(name, n, exp);
  endtask

  task automatic wait_fall(input string name, input int exp);
    int n;
    n = 0;
    for (int i = 1; i <= 2000; i++) begin
      step();
      n = i;
      if (!sys_reset_n) break;
    end
    check(name, n, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st [1:40];
    int n, low;

    // Power-up with lock already present.
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (5) step();
    check("reset_sys_reset_n", int'(sys_reset_n), 0);
    check("reset_sys_ready", int'(sys_ready), 0);
    check("reset_state", int'(state), 0);
    rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      st[i] = int'(state);
      n = i;
      if (sys_reset_n) break;
    end
    check("powerup_latency", n, 15);
    check("powerup_ready", int'(sys_ready), 1);
    check("powerup_st2_wait", st[2], 0);
    check("powerup_st3_filter", st[3], 1);
    check("powerup_st6_filter", st[6], 1);
    check("powerup_st7_hold", st[7], 2);
    check("powerup_st14_hold", st[14], 2);
    check("powerup_st15_run", st[15], 3);

    // Lock loss in RUN.
    locked = 1'b0;
    wait_fall("loss_latency", 3);
    check("loss_state", int'(state), 0);
    check("loss_count", int'(lock_loss_count), 1);
    check("loss_sticky", int'(lock_lost), 1);
    repeat (3) step();

    // Filter abort.
    locked = 1'b1;
    repeat (3) step();
    locked = 1'b0;
    step();
    locked = 1'b1;
    wait_rise("abort_relatch", 15);

    // Software reset re-runs HOLD only.
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    check("swreq_immediate_low", int'(sys_reset_n), 0);
    check("swreq_state_hold", int'(state), 2);
    low = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (sys_reset_n) break;
      low++;
    end
    check("swreq_low_cycles", low, HC);
    check("swreq_count_kept", int'(lock_loss_count), 1);

    // Loss and software request on the same edge.
    locked = 1'b0;
    repeat (2) step();
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    check("loss_sw_state", int'(state), 0);
    check("loss_sw_count", int'(lock_loss_count), 2);
    locked = 1'b1;
    wait_rise("loss_sw_recover", 15);

    // Loss and clear on the same edge.
    locked = 1'b0;
    repeat (2) step();
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    check("loss_clear_count", int'(lock_loss_count), 1);
    check("loss_clear_sticky", int'(lock_lost), 1);
    locked = 1'b1;
    wait_rise("loss_clear_recover", 15);

    // Saturation of the loss counter.
    for (int k = 0; k < 300; k++) begin
      locked = 1'b0;
      repeat (3) step();
      locked = 1'b1;
      n = 0;
      for (int i = 1; i <= 100; i++) begin
        step();
        n = i;
        if (sys_reset_n) break;
      end
      if (n != 15) check("sat_recover", n, 15);
    end
    check("sat_count", int'(lock_loss_count), LOSS_MAX);
    check("sat_sticky", int'(lock_lost), 1);
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    check("clear_count", int'(lock_loss_count), 0);
    check("clear_sticky", int'(lock_lost), 0);

    // Async reset during HOLD.
    locked = 1'b0;
    repeat (4) step();
    locked = 1'b1;
    repeat (10) step();
    check("hold_reached", int'(state), 2);
    check("hold_count_before", int'(lock_loss_count), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_sys_reset_n", int'(sys_reset_n), 0);
    check("async_sys_ready", int'(sys_ready), 0);
    check("async_state", int'(state), 0);
    check("async_count", int'(lock_loss_count), 0);
    check("async_sticky", int'(lock_lost), 0);
    step();
    rst_n = 1'b1;
    wait_rise("async_recover", 15);

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) locked = ~locked;
      sw_reset_req = ($urandom_range(0, 24) == 0);
      clear_status = ($urandom_range(0, 59) == 0);
      step();
    end
    sw_reset_req = 1'b0;
    clear_status = 1'b0;
    step();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
